hangman_guess_issuer: RTL and testbench

Player/host front end driving the `Game_Logic` core's input side.
- Collects a 5-letter secret word from keypad strobes and confirms it with `toggle_state`.
- Submits player guesses one at a time, only when the core is ready, and rejects letters already guessed.
- Tracks win/loss from the core's `correct`/`incorrect` counters and ends the round with a `gameEnd` request.
- Sits between the keypad/UART decoder and `Game_Logic`.

---
 rtl/hangman_guess_issuer.sv | 238 +++++++++++++++++++++++
 tb/tb_hangman_guess_issuer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_guess_issuer.sv
// Front end for the Game_Logic core: collects the secret word from keypad
// strobes, arms the core, issues de-duplicated guesses through a one-deep
// pending buffer and tracks the win/loss outcome of the round.
module hangman_guess_issuer #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        nRst_i,
  input  logic        key_valid_i,
  input  logic [7:0]  key_char_i,
  input  logic        key_enter_i,
  input  logic        key_clear_i,
  input  logic        new_game_i,
  input  logic        game_rdy_i,
  input  logic        red_busy_i,
  input  logic [2:0]  correct_i,
  input  logic [2:0]  incorrect_i,
  output logic [7:0]  guess_o,
  output logic [39:0] setWord_o,
  output logic        toggle_state_o,
  output logic        gameEnd_o,
  output logic        err_o,
  output logic        won_o,
  output logic        lost_o,
  output logic [25:0] guessed_mask_o,
  output logic [2:0]  entry_cnt_o
);

  localparam logic [2:0] S_ENTRY     = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ENDING    = 3'd7;

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [39:0]   word_q, word_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    guess_q, guess_d;
  logic [25:0]   mask_q, mask_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    pend_c_q, pend_c_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          toggle_q, toggle_d;
  logic          gend_q, gend_d;
  logic          err_q, err_d;
  logic          won_q, won_d;
  logic          lost_q, lost_d;

  logic          key_ok;
  logic [7:0]    key_off, pend_off;
  logic [4:0]    key_idx, pend_idx;
  logic          core_idle;

  assign key_ok    = (key_char_i >= 8'h41) && (key_char_i <= 8'h5A);
  assign key_off   = key_char_i - 8'h41;
  assign key_idx   = key_off[4:0];
  assign pend_off  = pend_c_q - 8'h41;
  assign pend_idx  = pend_off[4:0];
  assign core_idle = game_rdy_i && !red_busy_i;

  // Next-state logic for the round controller and all datapath registers
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    guess_d  = guess_q;
    mask_d   = mask_q;
    pend_v_d = pend_v_q;
    pend_c_d = pend_c_q;
    tmo_d    = tmo_q;
    toggle_d = 1'b0;
    gend_d   = gend_q;
    err_d    = 1'b0;
    won_d    = won_q;
    lost_d   = lost_q;

    if (new_game_i) begin
      // Abort/finish from anywhere; the core is told via gameEnd.
      state_d = S_ENDING;
      gend_d  = 1'b1;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (key_clear_i) begin
            word_d = '0;
            cnt_d  = '0;
          end else if (key_enter_i) begin
            if (cnt_q == 3'd5) state_d = S_ARM;
            else               err_d   = 1'b1;
          end else if (key_valid_i) begin
            if (key_ok && cnt_q < 3'd5) begin
              word_d = {word_q[31:0], key_char_i};
              cnt_d  = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        S_ARM: begin
          // guess is still zero here, so the confirm pulse sees a clean bus.
          if (game_rdy_i) begin
            toggle_d = 1'b1;
            state_d  = S_PLAY;
          end
        end

        S_PLAY: begin
          if (pend_v_q && core_idle) begin
            guess_d          = pend_c_q;
            mask_d[pend_idx] = 1'b1;
            pend_v_d         = 1'b0;
            tmo_d            = '0;
            state_d          = S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          // Guess and mask bit stay even if the core never acknowledges.
          if (red_busy_i) begin
            state_d = S_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_PLAY;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (core_idle) state_d = S_SETTLE;
        end

        S_SETTLE: begin
          // Counters have had a cycle to settle; a win outranks a loss.
          if (correct_i == 3'd5) begin
            won_d   = 1'b1;
            state_d = S_DONE;
          end else if (incorrect_i == 3'd6) begin
            lost_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_PLAY;
          end
        end

        S_ENDING: begin
          if (core_idle) begin
            gend_d   = 1'b0;
            guess_d  = '0;
            word_d   = '0;
            mask_d   = '0;
            pend_v_d = 1'b0;
            pend_c_d = '0;
            cnt_d    = '0;
            won_d    = 1'b0;
            lost_d   = 1'b0;
            tmo_d    = '0;
            state_d  = S_ENTRY;
          end
        end

        default: ;  // S_DONE: keys ignored until new_game
      endcase

      // Guess keys during the round: checked against the mask after any
      // issue this cycle, so a key arriving with an issue refills the buffer.
      if (key_valid_i && (state_q == S_PLAY || state_q == S_WAIT_ACK ||
                          state_q == S_WAIT_DONE || state_q == S_SETTLE)) begin
        if (!key_ok || mask_d[key_idx] ||
            (pend_v_d && pend_c_d == key_char_i)) begin
          err_d = 1'b1;
        end else if (pend_v_d) begin
          err_d = 1'b1;
        end else if (state_q == S_PLAY && state_d == S_PLAY && core_idle) begin
          // Empty buffer and idle core: bypass straight to the core.
          guess_d         = key_char_i;
          mask_d[key_idx] = 1'b1;
          tmo_d           = '0;
          state_d         = S_WAIT_ACK;
        end else begin
          pend_v_d = 1'b1;
          pend_c_d = key_char_i;
        end
      end
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!nRst_i) begin
      state_q  <= S_ENTRY;
      word_q   <= '0;
      cnt_q    <= '0;
      guess_q  <= '0;
      mask_q   <= '0;
      pend_v_q <= 1'b0;
      pend_c_q <= '0;
      tmo_q    <= '0;
      toggle_q <= 1'b0;
      gend_q   <= 1'b0;
      err_q    <= 1'b0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      guess_q  <= guess_d;
      mask_q   <= mask_d;
      pend_v_q <= pend_v_d;
      pend_c_q <= pend_c_d;
      tmo_q    <= tmo_d;
      toggle_q <= toggle_d;
      gend_q   <= gend_d;
      err_q    <= err_d;
      won_q    <= won_d;
      lost_q   <= lost_d;
    end
  end

  assign guess_o        = guess_q;
  assign setWord_o      = word_q;
  assign toggle_state_o = toggle_q;
  assign gameEnd_o      = gend_q;
  assign err_o          = err_q;
  assign won_o          = won_q;
  assign lost_o         = lost_q;
  assign guessed_mask_o = mask_q;
  assign entry_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hangman_guess_issuer.sv
// Bench for hangman_guess_issuer: random word-entry run against a queue
// model, a table of guesses, and hand sequences for the multi-cycle cases.
module tb_hangman_guess_issuer;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        nRst, key_valid, key_enter, key_clear, new_game, game_rdy, red_busy;
  logic [7:0]  key_char;
  logic [2:0]  correct, incorrect;
  logic [7:0]  guess;
  logic [39:0] setWord;
  logic        toggle_state, gameEnd, err, won, lost;
  logic [25:0] guessed_mask;
  logic [2:0]  entry_cnt;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_mask = '0;

  hangman_guess_issuer #(.ACK_TIMEOUT(T)) dut (
    .clk_i(clk), .nRst_i(nRst), .key_valid_i(key_valid), .key_char_i(key_char),
    .key_enter_i(key_enter), .key_clear_i(key_clear), .new_game_i(new_game),
    .game_rdy_i(game_rdy), .red_busy_i(red_busy), .correct_i(correct),
    .incorrect_i(incorrect), .guess_o(guess), .setWord_o(setWord),
    .toggle_state_o(toggle_state), .gameEnd_o(gameEnd), .err_o(err),
    .won_o(won), .lost_o(lost), .guessed_mask_o(guessed_mask),
    .entry_cnt_o(entry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic       exp_err;
    logic [2:0] c_after;
    logic [2:0] i_after;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    key_valid = 0; key_enter = 0; key_clear = 0; new_game = 0;
  endtask

  task automatic key(input logic [7:0] c);
    idle(); key_valid = 1; key_char = c; tick(); key_valid = 0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_a"}, {11'd0, guess, setWord, toggle_state, gameEnd, err, won, lost}, 64'd0);
    chk({nm, "_b"}, {35'd0, guessed_mask, entry_cnt}, 64'd0);
  endtask

  // Core evaluates the outstanding guess: busy for one cycle, then idle
  // with updated counters; two more edges bring the issuer past settle.
  task automatic ack_round(input logic [2:0] c, input logic [2:0] i);
    idle(); red_busy = 1; tick();
    red_busy = 0; correct = c; incorrect = i; tick(); tick();
  endtask

  task automatic set_bit(input logic [7:0] c);
    exp_mask[c - 8'h41] = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] q[$];
    logic [39:0] w;
    logic [7:0] c;
    int r;
    logic kv, kc, ke, exp_err;

    tbl[0] = '{8'h4C, 1'b0, 3'd1, 3'd0};  // L: new
    tbl[1] = '{8'h4C, 1'b1, 3'd1, 3'd0};  // L again: duplicate
    tbl[2] = '{8'h61, 1'b1, 3'd1, 3'd0};  // 'a': not an upper-case letter
    tbl[3] = '{8'h5A, 1'b0, 3'd1, 3'd1};  // Z: new, wrong
    tbl[4] = '{8'h48, 1'b0, 3'd2, 3'd1};  // H: new
    tbl[5] = '{8'h5A, 1'b1, 3'd2, 3'd1};  // Z again: duplicate

    nRst = 0; idle(); key_char = 0; game_rdy = 0; red_busy = 0;
    correct = 0; incorrect = 0;
    tick(); tick();
    check_zero("reset");
    nRst = 1;

    // Random entry: model holds the word as a queue of letters.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 15);
      kc = (r == 0);
      ke = (r == 1) && (q.size() < 5);
      kv = $urandom_range(0, 3) != 0;
      c  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h41 + $urandom_range(0, 25));
      key_valid = kv; key_char = c; key_clear = kc; key_enter = ke;
      exp_err = 0;
      if (kc) q.delete();
      else if (ke) exp_err = 1;
      else if (kv) begin
        if (c >= 8'h41 && c <= 8'h5A && q.size() < 5) q.push_back(c);
        else exp_err = 1;
      end
      tick();
      w = '0;
      for (int i = 0; i < q.size(); i++) w |= 40'(q[i]) << (8 * (q.size() - 1 - i));
      chk("rnd_word", 64'(setWord), 64'(w));
      chk("rnd_cnt", 64'(entry_cnt), 64'(q.size()));
      chk("rnd_err", 64'(err), 64'(exp_err));
    end
    idle();

    // Early enter, clear, then HELLO
    idle(); key_clear = 1; tick(); idle();
    key(8'h48); key(8'h45); key(8'h4C);
    key_enter = 1; tick(); key_enter = 0;
    chk("early_enter_err", 64'(err), 64'd1);
    chk("early_enter_cnt", 64'(entry_cnt), 64'd3);
    key_clear = 1; tick(); key_clear = 0;
    chk("clear_cnt", 64'(entry_cnt), 64'd0);
    chk("clear_word", 64'(setWord), 64'd0);
    key(8'h48); key(8'h45); key(8'h4C); key(8'h4C); key(8'h4F);
    chk("hello_word", 64'(setWord), 64'h48454C4C4F);
    chk("hello_cnt", 64'(entry_cnt), 64'd5);
    key(8'h58);
    chk("full_err", 64'(err), 64'd1);
    chk("full_word", 64'(setWord), 64'h48454C4C4F);

    // Arm: no toggle until the core is ready, then exactly one pulse
    key_enter = 1; tick(); key_enter = 0;
    tick();
    chk("arm_no_toggle", 64'(toggle_state), 64'd0);
    chk("arm_guess0", 64'(guess), 64'd0);
    game_rdy = 1; tick();
    chk("toggle_on", 64'(toggle_state), 64'd1);
    chk("toggle_guess0", 64'(guess), 64'd0);
    tick();
    chk("toggle_off", 64'(toggle_state), 64'd0);
    chk("word_frozen", 64'(setWord), 64'h48454C4C4F);

    // Guess table with the core idle between guesses
    c = 8'h00;
    foreach (tbl[k]) begin
      key(tbl[k].ch);
      chk("tbl_err", 64'(err), 64'(tbl[k].exp_err));
      if (!tbl[k].exp_err) begin
        set_bit(tbl[k].ch);
        c = tbl[k].ch;
      end
      chk("tbl_guess", 64'(guess), 64'(c));
      chk("tbl_mask", 64'(guessed_mask), 64'(exp_mask));
      if (!tbl[k].exp_err) ack_round(tbl[k].c_after, tbl[k].i_after);
      else tick();
      chk("tbl_nowin", 64'({won, lost}), 64'd0);
    end

    // Core busy: A buffers, B finds the buffer full
    red_busy = 1;
    key(8'h41);
    chk("buf_a_noerr", 64'(err), 64'd0);
    chk("buf_a_held", 64'(guess), 64'h48);
    key(8'h42);
    chk("buf_b_err", 64'(err), 64'd1);
    tick();
    chk("buf_still_held", 64'(guess), 64'h48);
    red_busy = 0; tick();
    set_bit(8'h41);
    chk("buf_a_issue", 64'(guess), 64'h41);
    chk("buf_a_mask", 64'(guessed_mask), 64'(exp_mask));
    ack_round(3'd2, 3'd2);

    // No acknowledge: err exactly T cycles after issue
    key(8'h43);
    set_bit(8'h43);
    chk("tmo_issue", 64'(guess), 64'h43);
    for (int i = 1; i < T; i++) begin
      tick();
      chk("tmo_quiet", 64'(err), 64'd0);
    end
    tick();
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_guess_kept", 64'(guess), 64'h43);
    chk("tmo_mask_kept", 64'(guessed_mask), 64'(exp_mask));
    key(8'h44);
    set_bit(8'h44);
    chk("tmo_back_play", 64'(guess), 64'h44);
    chk("tmo_err_off", 64'(err), 64'd0);
    ack_round(3'd2, 3'd4);

    // Loss, keys ignored afterwards, then new game
    key(8'h51);
    chk("q_issue", 64'(guess), 64'h51);
    ack_round(3'd2, 3'd6);
    chk("lost_set", 64'({won, lost}), 64'b01);
    key(8'h52);
    chk("done_noerr", 64'(err), 64'd0);
    chk("done_guess", 64'(guess), 64'h51);
    game_rdy = 0; new_game = 1; tick(); new_game = 0;
    chk("gend_on", 64'(gameEnd), 64'd1);
    tick();
    chk("gend_held", 64'(gameEnd), 64'd1);
    game_rdy = 1; tick();
    check_zero("ended");
    key(8'h4B);
    chk("entry_again", 64'({setWord, entry_cnt}), {21'd0, 40'h4B, 3'd1});

    // Reset mid-entry discards the partial word
    key(8'h4D);
    nRst = 0; tick(); nRst = 1;
    check_zero("midreset");

    // Win has priority when both counters hit their limit
    exp_mask = '0;
    key(8'h41); key(8'h42); key(8'h43); key(8'h44); key(8'h45);
    correct = 0; incorrect = 0;
    key_enter = 1; tick(); key_enter = 0;
    tick();
    chk("win_toggle", 64'(toggle_state), 64'd1);
    key(8'h41);
    set_bit(8'h41);
    chk("win_issue", 64'({guess, guessed_mask}), {30'd0, 8'h41, exp_mask});
    ack_round(3'd5, 3'd6);
    chk("won_first", 64'({won, lost}), 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
